// File: rtl/fetch_decode_assembler.sv
// IF/ID pipeline register that assembles opcode + 16-bit immediate pairs
// from a one-word-per-cycle fetch stream into single decode packets, with
// stall (hold) and flush (bubble injection) control from hazard logic.
module fetch_decode_assembler #(
    parameter logic [15:0] NOP_WORD  = 16'h4000,
    parameter logic [4:0]  IMM_MASK  = 5'b11000,
    parameter logic [4:0]  IMM_MATCH = 5'b11000,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_valid,
    input  logic [15:0]          fetch_word,
    input  logic [31:0]          fetch_pc_plus_one,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 fetch_ready,
    output logic                 imm_pending,
    output logic                 id_valid,
    output logic [15:0]          id_instruction,
    output logic [15:0]          id_immediate,
    output logic                 id_has_imm,
    output logic [31:0]          id_pc_plus_one,
    output logic [CNT_WIDTH-1:0] instr_count
);

    typedef enum logic {
        ST_FIRST    = 1'b0,
        ST_IMM_WAIT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           hold_word_q, hold_word_d;
    logic                  id_valid_q, id_valid_d;
    logic [15:0]           id_instruction_q, id_instruction_d;
    logic [15:0]           id_immediate_q, id_immediate_d;
    logic                  id_has_imm_q, id_has_imm_d;
    logic [31:0]           id_pc_plus_one_q, id_pc_plus_one_d;
    logic [CNT_WIDTH-1:0]  instr_count_q, instr_count_d;
    logic                  needs_imm;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Only meaningful for an opcode word; the immediate word is never tested.
    assign needs_imm   = ((fetch_word[15:11] & IMM_MASK) == IMM_MATCH);
    // Flush drops the presented word, so fetch may advance past it.
    assign fetch_ready = !stall || flush;
    assign imm_pending = (state_q == ST_IMM_WAIT);

    assign id_valid       = id_valid_q;
    assign id_instruction = id_instruction_q;
    assign id_immediate   = id_immediate_q;
    assign id_has_imm     = id_has_imm_q;
    assign id_pc_plus_one = id_pc_plus_one_q;
    assign instr_count    = instr_count_q;

    // Next-state / next-packet selection: flush > stall > normal assembly.
    always_comb begin
        state_d          = state_q;
        hold_word_d      = hold_word_q;
        id_valid_d       = id_valid_q;
        id_instruction_d = id_instruction_q;
        id_immediate_d   = id_immediate_q;
        id_has_imm_d     = id_has_imm_q;
        id_pc_plus_one_d = id_pc_plus_one_q;
        instr_count_d    = instr_count_q;

        if (flush) begin
            state_d          = ST_FIRST;
            hold_word_d      = '0;
            id_valid_d       = 1'b0;
            id_instruction_d = NOP_WORD;
            id_immediate_d   = '0;
            id_has_imm_d     = 1'b0;
        end else if (!stall) begin
            // Bubble unless a packet completes below; pc is left as-is.
            id_valid_d       = 1'b0;
            id_instruction_d = NOP_WORD;
            id_immediate_d   = '0;
            id_has_imm_d     = 1'b0;
            case (state_q)
                ST_FIRST: begin
                    if (fetch_valid) begin
                        if (needs_imm) begin
                            hold_word_d = fetch_word;
                            state_d     = ST_IMM_WAIT;
                        end else begin
                            id_valid_d       = 1'b1;
                            id_instruction_d = fetch_word;
                            id_pc_plus_one_d = fetch_pc_plus_one;
                            instr_count_d    = instr_count_q + CNT_ONE;
                        end
                    end
                end
                ST_IMM_WAIT: begin
                    if (fetch_valid) begin
                        id_valid_d       = 1'b1;
                        id_instruction_d = hold_word_q;
                        id_immediate_d   = fetch_word;
                        id_has_imm_d     = 1'b1;
                        id_pc_plus_one_d = fetch_pc_plus_one;
                        instr_count_d    = instr_count_q + CNT_ONE;
                        state_d          = ST_FIRST;
                    end
                end
                default: state_d = ST_FIRST;
            endcase
        end
    end

    // State and registered decode packet; reset may arrive mid-assembly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_FIRST;
            hold_word_q      <= '0;
            id_valid_q       <= 1'b0;
            id_instruction_q <= NOP_WORD;
            id_immediate_q   <= '0;
            id_has_imm_q     <= 1'b0;
            id_pc_plus_one_q <= '0;
            instr_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            hold_word_q      <= hold_word_d;
            id_valid_q       <= id_valid_d;
            id_instruction_q <= id_instruction_d;
            id_immediate_q   <= id_immediate_d;
            id_has_imm_q     <= id_has_imm_d;
            id_pc_plus_one_q <= id_pc_plus_one_d;
            instr_count_q    <= instr_count_d;
        end
    end

endmodule

// File: tb/tb_fetch_decode_assembler.sv
// Scoreboard bench: a behavioural model pushes the expected decode packet
// for every driven cycle; it is popped and compared one edge later. A second
// instance with a 4-bit counter shares the stimulus to exercise wrap.
module tb_fetch_decode_assembler;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [15:0] fetch_word;
    logic [31:0] fetch_pc_plus_one;
    logic        stall, flush;

    logic        fetch_ready, imm_pending, id_valid, id_has_imm;
    logic [15:0] id_instruction, id_immediate;
    logic [31:0] id_pc_plus_one, instr_count;

    logic        fr4, ip4, iv4, ih4;
    logic [15:0] ii4, im4;
    logic [31:0] ipc4;
    logic [3:0]  cnt4;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fetch_decode_assembler u_dut (
        .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_word(fetch_word),
        .fetch_pc_plus_one(fetch_pc_plus_one), .stall(stall), .flush(flush),
        .fetch_ready(fetch_ready), .imm_pending(imm_pending), .id_valid(id_valid),
        .id_instruction(id_instruction), .id_immediate(id_immediate), .id_has_imm(id_has_imm),
        .id_pc_plus_one(id_pc_plus_one), .instr_count(instr_count)
    );

    fetch_decode_assembler #(.CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_word(fetch_word),
        .fetch_pc_plus_one(fetch_pc_plus_one), .stall(stall), .flush(flush),
        .fetch_ready(fr4), .imm_pending(ip4), .id_valid(iv4),
        .id_instruction(ii4), .id_immediate(im4), .id_has_imm(ih4),
        .id_pc_plus_one(ipc4), .instr_count(cnt4)
    );

    typedef struct {
        logic        v;
        logic [15:0] ins;
        logic [15:0] imm;
        logic        has;
        logic [31:0] pc;
        logic [31:0] cnt;
    } pkt_t;

    pkt_t sb[$];

    // model state
    logic        m_wait;
    logic [15:0] m_hold;
    pkt_t        m_out;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 1'b0;
        m_hold = '0;
        m_out  = '{v: 1'b0, ins: 16'h4000, imm: 16'h0, has: 1'b0, pc: 32'h0, cnt: 32'h0};
    endtask

    task automatic chk_outputs(input string tag, input pkt_t e);
        chk({tag, ".valid"}, 32'(id_valid), 32'(e.v));
        chk({tag, ".instr"}, 32'(id_instruction), 32'(e.ins));
        chk({tag, ".imm"}, 32'(id_immediate), 32'(e.imm));
        chk({tag, ".has_imm"}, 32'(id_has_imm), 32'(e.has));
        chk({tag, ".pc"}, id_pc_plus_one, e.pc);
        chk({tag, ".count"}, instr_count, e.cnt);
        chk({tag, ".count4"}, 32'(cnt4), 32'(e.cnt[3:0]));
        chk({tag, ".valid4"}, 32'(iv4), 32'(e.v));
    endtask

    // Drive one cycle, predict its packet, compare after the edge.
    task automatic step(input string tag, input logic v, input logic [15:0] w,
                        input logic [31:0] pc, input logic st, input logic fl);
        pkt_t e;
        fetch_valid = v; fetch_word = w; fetch_pc_plus_one = pc; stall = st; flush = fl;
        #1;
        chk({tag, ".ready"}, 32'(fetch_ready), 32'(!st || fl));
        chk({tag, ".pending"}, 32'(imm_pending), 32'(m_wait));
        if (fl) begin
            m_wait = 1'b0;
            m_hold = '0;
            m_out.v = 1'b0; m_out.ins = 16'h4000; m_out.imm = '0; m_out.has = 1'b0;
        end else if (!st) begin
            m_out.v = 1'b0; m_out.ins = 16'h4000; m_out.imm = '0; m_out.has = 1'b0;
            if (v && m_wait) begin
                m_out = '{v: 1'b1, ins: m_hold, imm: w, has: 1'b1, pc: pc, cnt: m_out.cnt + 1};
                m_wait = 1'b0;
            end else if (v && w[15:14] == 2'b11) begin
                m_hold = w;
                m_wait = 1'b1;
            end else if (v) begin
                m_out = '{v: 1'b1, ins: w, imm: 16'h0, has: 1'b0, pc: pc, cnt: m_out.cnt + 1};
            end
        end
        sb.push_back(m_out);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk_outputs(tag, e);
    endtask

    initial begin
        pkt_t rst_exp;
        reset = 1'b1; fetch_valid = 0; fetch_word = '0; fetch_pc_plus_one = '0;
        stall = 0; flush = 0;
        model_reset();
        rst_exp = m_out;
        @(posedge clk); @(posedge clk); #1;
        chk_outputs("reset", rst_exp);
        chk("reset.pending", 32'(imm_pending), 32'h0);
        reset = 1'b0;

        // single-word instructions
        step("single0", 1, 16'h0801, 33, 0, 0);
        step("single1", 1, 16'h1002, 34, 0, 0);
        step("idle", 0, 16'h0000, 0, 0, 0);

        // opcode + immediate
        step("op", 1, 16'hC805, 41, 0, 0);
        chk("op.pending", 32'(imm_pending), 32'h1);
        step("imm", 1, 16'h00FF, 42, 0, 0);
        chk("imm.pending", 32'(imm_pending), 32'h0);

        // immediate word that itself looks like an opcode needing an immediate
        step("op2", 1, 16'hC805, 50, 0, 0);
        step("immlook", 1, 16'hC000, 51, 0, 0);
        chk("immlook.pending", 32'(imm_pending), 32'h0);

        // gap while waiting for immediate
        step("op3", 1, 16'hD123, 60, 0, 0);
        step("gap", 0, 16'h0000, 0, 0, 0);
        step("imm3", 1, 16'h1234, 62, 0, 0);

        // stall in IMM_WAIT
        step("op4", 1, 16'hC805, 70, 0, 0);
        for (int i = 0; i < 3; i++) step("stall", 1, 16'h00FF, 71, 1, 0);
        chk("stall.pending", 32'(imm_pending), 32'h1);
        step("unstall", 1, 16'h00FF, 71, 0, 0);

        // flush in IMM_WAIT with a valid word presented
        step("op5", 1, 16'hC805, 80, 0, 0);
        step("flush", 1, 16'h00AA, 81, 0, 1);
        chk("flush.pending", 32'(imm_pending), 32'h0);
        step("after_flush", 1, 16'h0801, 82, 0, 0);

        // flush and stall together
        step("op6", 1, 16'hE001, 90, 0, 0);
        step("flushstall", 1, 16'h5555, 91, 1, 1);
        step("after_fs", 1, 16'h2002, 92, 0, 0);

        // enough packets to wrap the 4-bit counter
        for (int i = 0; i < 16; i++) step("wrap", 1, 16'(16'h0100 + i), 32'(100 + i), 0, 0);

        // random mix
        for (int i = 0; i < 80; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            step("rand", ($urandom_range(0, 3) != 0), w, 32'($urandom),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
        end

        // async reset between edges while waiting for an immediate
        step("op7", 1, 16'hC805, 200, 0, 0);
        if (!imm_pending) step("op7b", 1, 16'hC805, 200, 0, 0);
        reset = 1'b1;
        #2;
        model_reset();
        chk_outputs("areset", m_out);
        chk("areset.pending", 32'(imm_pending), 32'h0);
        #1;
        reset = 1'b0;
        step("post_reset", 1, 16'h0801, 300, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
